// File: rtl/booth16_digit_sequencer_if.sv
// Handshake and digit-stream bundle between the Booth front-end sequencer and its user.
// The master issues operands; the slave (sequencer) returns the recoded digit stream.
interface booth16_digit_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             ready;
    logic             load;
    logic [WIDTH-1:0] mcand_q;
    logic             digit_valid;
    logic             digit_neg;
    logic [3:0]       digit_mag;
    logic             digit_last;
    logic             done;

    modport master (
        output start, abort, multiplicand, multiplier,
        input  ready, load, mcand_q, digit_valid, digit_neg, digit_mag, digit_last, done
    );

    modport slave (
        input  start, abort, multiplicand, multiplier,
        output ready, load, mcand_q, digit_valid, digit_neg, digit_mag, digit_last, done
    );
endinterface

// File: rtl/booth16_digit_sequencer.sv
// Radix-16 Booth front end: latches an operand pair, pulses load, then streams
// WIDTH/4 signed digits LSB first and flags completion.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a new operand pair; start accepted here only
// ST_CLEAR | one-cycle load pulse clearing the pp/carry shift register
// ST_RUN   | one Booth digit per cycle, multiplier shifted right by 4
// ST_DONE  | one-cycle done pulse, then back to idle
module booth16_digit_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    booth16_digit_sequencer_if.slave bus
);

    localparam int N_DIGITS = WIDTH / 4;
    localparam int CNT_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   mplr_q;
    logic [WIDTH-1:0]   mcand_r;
    logic               g_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               accept;
    logic               advance;
    logic [3:0]         digit_pos;
    logic [3:0]         digit_mag_raw;
    logic               digit_neg_raw;

    assign accept  = (state_q == ST_IDLE) && bus.start;
    assign advance = (state_q == ST_RUN) && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = bus.abort ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Multiplier window, guard bit and digit down-counter; mcand is held on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mplr_q  <= '0;
            mcand_r <= '0;
            g_q     <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            mplr_q  <= bus.multiplier;
            mcand_r <= bus.multiplicand;
            g_q     <= 1'b0;
            cnt_q   <= CNT_W'(N_DIGITS - 1);
        end else if (advance) begin
            mplr_q  <= {{4{mplr_q[WIDTH-1]}}, mplr_q[WIDTH-1:4]};
            g_q     <= mplr_q[3];
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    // d = -8*m3 + (4*m2 + 2*m1 + m0 + g); the bracketed part is 0..8.
    always_comb begin
        digit_pos = {1'b0, mplr_q[2:0]} + {3'b000, g_q};
        if (mplr_q[3]) begin
            digit_mag_raw = 4'd8 - digit_pos;
            digit_neg_raw = (digit_pos != 4'd8);
        end else begin
            digit_mag_raw = digit_pos;
            digit_neg_raw = 1'b0;
        end
    end

    always_comb begin
        bus.ready       = 1'b0;
        bus.load        = 1'b0;
        bus.done        = 1'b0;
        bus.digit_valid = 1'b0;
        bus.digit_neg   = 1'b0;
        bus.digit_mag   = 4'd0;
        bus.digit_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.ready = 1'b1;
            end
            ST_CLEAR: begin
                bus.load = 1'b1;
            end
            ST_RUN: begin
                bus.digit_valid = 1'b1;
                bus.digit_neg   = digit_neg_raw;
                bus.digit_mag   = digit_mag_raw;
                bus.digit_last  = (cnt_q == '0);
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.ready = 1'b0;
            end
        endcase
    end

    assign bus.mcand_q = mcand_r;

endmodule

// File: tb/tb_booth16_digit_sequencer.sv
// Self-checking bench for booth16_digit_sequencer at WIDTH=8 and WIDTH=32.
// Expected digits are queued at stimulus time and consumed by per-instance monitors.
module tb_booth16_digit_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    booth16_digit_sequencer_if #(.WIDTH(8))  if8 ();
    booth16_digit_sequencer_if #(.WIDTH(32)) if32 ();

    booth16_digit_sequencer #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    booth16_digit_sequencer #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    typedef struct packed {
        logic       neg;
        logic [3:0] mag;
        logic       last;
    } digit_t;

    digit_t q8[$];
    digit_t q32[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    longint sum8  = 0;
    longint sum32 = 0;
    int     idx8  = 0;
    int     idx32 = 0;

    // Reference recoding straight from the digit definition, bit positions of the original operand.
    function automatic digit_t model_digit(input logic [31:0] m, input int i, input int n);
        int     v;
        int     prev;
        digit_t d;
        prev = (i == 0) ? 0 : int'(m[4*i-1]);
        v = -8 * int'(m[4*i+3]) + 4 * int'(m[4*i+2]) + 2 * int'(m[4*i+1]) + int'(m[4*i]) + prev;
        d.neg  = (v < 0);
        d.mag  = 4'((v < 0) ? -v : v);
        d.last = (i == n - 1);
        return d;
    endfunction

    function automatic longint digit_weight(input digit_t d, input int idx);
        longint w;
        w = longint'(1) << (4 * idx);
        return d.neg ? -(longint'(d.mag) * w) : (longint'(d.mag) * w);
    endfunction

    always @(negedge clk) begin : mon8
        digit_t got;
        digit_t exp;
        if (if8.digit_valid) begin
            got = {if8.digit_neg, if8.digit_mag, if8.digit_last};
            n_cmp++;
            if (q8.size() == 0) begin
                n_bad++;
                $display("FAIL digit8_unexpected got=%b exp=none", got);
            end else begin
                exp = q8.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL digit8 idx=%0d got neg=%b mag=%0d last=%b exp neg=%b mag=%0d last=%b",
                             idx8, got.neg, got.mag, got.last, exp.neg, exp.mag, exp.last);
                end
            end
            sum8 += digit_weight(got, idx8);
            idx8++;
        end
    end

    always @(negedge clk) begin : mon32
        digit_t got;
        digit_t exp;
        if (if32.digit_valid) begin
            got = {if32.digit_neg, if32.digit_mag, if32.digit_last};
            n_cmp++;
            if (q32.size() == 0) begin
                n_bad++;
                $display("FAIL digit32_unexpected got=%b exp=none", got);
            end else begin
                exp = q32.pop_front();
                if (got !== exp) begin
                    n_bad++;
                    $display("FAIL digit32 idx=%0d got neg=%b mag=%0d last=%b exp neg=%b mag=%0d last=%b",
                             idx32, got.neg, got.mag, got.last, exp.neg, exp.mag, exp.last);
                end
            end
            n_cmp++;
            if (got.mag > 4'd8 || (got.neg && got.mag == 4'd0)) begin
                n_bad++;
                $display("FAIL digit32_range got neg=%b mag=%0d exp mag<=8 and no -0", got.neg, got.mag);
            end
            sum32 += digit_weight(got, idx32);
            idx32++;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic push8(input logic [7:0] m);
        for (int i = 0; i < 2; i++) q8.push_back(model_digit({24'b0, m}, i, 2));
    endtask

    task automatic push32(input logic [31:0] m);
        for (int i = 0; i < 8; i++) q32.push_back(model_digit(m, i, 8));
    endtask

    // One WIDTH=8 operation from the current negedge; expected digits must already be queued.
    task automatic op8(input logic [7:0] m, input logic [7:0] mc, input logic ab, input string name);
        int   load_n = 0, done_n = 0, dv_n = 0, last_at = -1, done_at = -1, load_at = -1;
        logic mc_ok = 1'b1, busy_ok = 1'b1, ready_end = 1'b0;
        sum8 = 0;
        idx8 = 0;
        if8.multiplier   = m;
        if8.multiplicand = mc;
        if8.start        = 1'b1;
        if8.abort        = ab;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if8.start = 1'b0;
                if8.abort = 1'b0;
            end
            if (if8.load) begin load_n++; load_at = c; end
            if (if8.done) begin done_n++; done_at = c; end
            if (if8.digit_valid) dv_n++;
            if (if8.digit_last) last_at = c;
            if (c <= 4 && if8.mcand_q !== mc) mc_ok = 1'b0;
            if (c <= 4 && if8.ready) busy_ok = 1'b0;
            if (c == 5) ready_end = if8.ready;
        end
        n_cmp++;
        if (load_n != 1 || load_at != 1) begin
            n_bad++;
            $display("FAIL %s load got n=%0d at=%0d exp n=1 at=1", name, load_n, load_at);
        end
        n_cmp++;
        if (dv_n != 2 || last_at != 3) begin
            n_bad++;
            $display("FAIL %s digits got n=%0d last_at=%0d exp n=2 last_at=3", name, dv_n, last_at);
        end
        n_cmp++;
        if (done_n != 1 || done_at != 4 || ready_end !== 1'b1 || busy_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done got n=%0d at=%0d ready5=%b busy_ok=%b exp n=1 at=4 ready5=1 busy_ok=1",
                     name, done_n, done_at, ready_end, busy_ok);
        end
        n_cmp++;
        if (mc_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s mcand_q got unstable exp %h held", name, mc);
        end
        n_cmp++;
        if (sum8 !== longint'($signed(m)) || q8.size() != 0) begin
            n_bad++;
            $display("FAIL %s digit_sum got=%0d left=%0d exp=%0d left=0", name, sum8, q8.size(), $signed(m));
        end
    endtask

    task automatic op32(input logic [31:0] m, input logic [31:0] mc, input string name);
        int   load_n = 0, done_n = 0, dv_n = 0, last_at = -1, done_at = -1;
        logic mc_ok = 1'b1, ready_end = 1'b0;
        sum32 = 0;
        idx32 = 0;
        if32.multiplier   = m;
        if32.multiplicand = mc;
        if32.start        = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) if32.start = 1'b0;
            if (if32.load) load_n++;
            if (if32.done) begin done_n++; done_at = c; end
            if (if32.digit_valid) dv_n++;
            if (if32.digit_last) last_at = c;
            if (c <= 10 && if32.mcand_q !== mc) mc_ok = 1'b0;
            if (c == 11) ready_end = if32.ready;
        end
        n_cmp++;
        if (load_n != 1 || dv_n != 8 || last_at != 9) begin
            n_bad++;
            $display("FAIL %s stream got load=%0d dv=%0d last_at=%0d exp load=1 dv=8 last_at=9",
                     name, load_n, dv_n, last_at);
        end
        n_cmp++;
        if (done_n != 1 || done_at != 10 || ready_end !== 1'b1 || mc_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done got n=%0d at=%0d ready11=%b mc_ok=%b exp n=1 at=10 ready11=1 mc_ok=1",
                     name, done_n, done_at, ready_end, mc_ok);
        end
        n_cmp++;
        if (sum32 !== longint'($signed(m)) || q32.size() != 0) begin
            n_bad++;
            $display("FAIL %s digit_sum got=%0d left=%0d exp=%0d left=0", name, sum32, q32.size(), $signed(m));
        end
    endtask

    task automatic test_reset();
        logic [17:0] snap8;
        logic [41:0] snap32;
        if8.start = 1'b0;  if8.abort = 1'b0;  if8.multiplier = '0;  if8.multiplicand = '0;
        if32.start = 1'b0; if32.abort = 1'b0; if32.multiplier = '0; if32.multiplicand = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            snap8 = {if8.ready, if8.load, if8.done, if8.digit_valid, if8.digit_neg,
                     if8.digit_mag, if8.digit_last, if8.mcand_q};
            n_cmp++;
            if (snap8 !== {1'b1, 17'b0}) begin
                n_bad++;
                $display("FAIL reset_idle8 cycle=%0d got=%b exp=%b", c, snap8, {1'b1, 17'b0});
            end
        end
        snap32 = {if32.ready, if32.load, if32.done, if32.digit_valid, if32.digit_neg,
                  if32.digit_mag, if32.digit_last, if32.mcand_q};
        n_cmp++;
        if (snap32 !== {1'b1, 41'b0}) begin
            n_bad++;
            $display("FAIL reset_idle32 got=%h exp=%h", snap32, {1'b1, 41'b0});
        end
    endtask

    task automatic test_basic();
        q8.push_back({1'b1, 4'd1, 1'b0});
        q8.push_back({1'b0, 4'd8, 1'b1});
        op8(8'h7F, 8'h05, 1'b0, "basic_7f");
    endtask

    task automatic test_edges();
        q8.push_back({1'b0, 4'd0, 1'b0});
        q8.push_back({1'b1, 4'd8, 1'b1});
        op8(8'h80, 8'hA5, 1'b0, "edge_80");
        q8.push_back({1'b1, 4'd1, 1'b0});
        q8.push_back({1'b0, 4'd0, 1'b1});
        op8(8'hFF, 8'h5A, 1'b0, "edge_ff");
        q8.push_back({1'b0, 4'd0, 1'b0});
        q8.push_back({1'b0, 4'd0, 1'b1});
        op8(8'h00, 8'hFF, 1'b0, "edge_00");
    endtask

    task automatic test_start_abort_idle();
        q8.push_back({1'b0, 4'd0, 1'b0});
        q8.push_back({1'b1, 4'd8, 1'b1});
        op8(8'h80, 8'h33, 1'b1, "start_abort_idle");
    endtask

    task automatic test_start_in_run();
        int load_n = 0, done_n = 0, dv_n = 0, done_at = -1;
        push8(8'h7F);
        sum8 = 0;
        idx8 = 0;
        if8.multiplier   = 8'h7F;
        if8.multiplicand = 8'h11;
        if8.start        = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (if8.load) load_n++;
            if (if8.done) begin done_n++; done_at = c; end
            if (if8.digit_valid) dv_n++;
            if (c == 1) if8.start = 1'b0;
            if (c == 2) begin
                if8.start      = 1'b1;
                if8.multiplier = 8'h12;
            end
            if (c == 3) if8.start = 1'b0;
        end
        n_cmp++;
        if (load_n != 1 || done_n != 1 || done_at != 4 || dv_n != 2) begin
            n_bad++;
            $display("FAIL start_in_run got load=%0d done=%0d at=%0d dv=%0d exp load=1 done=1 at=4 dv=2",
                     load_n, done_n, done_at, dv_n);
        end
        n_cmp++;
        if (sum8 !== 64'sd127 || q8.size() != 0) begin
            n_bad++;
            $display("FAIL start_in_run digit_sum got=%0d exp=127", sum8);
        end
    endtask

    task automatic test_random();
        logic [31:0] specials [5] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        logic [31:0] m;
        for (int k = 0; k < 2000; k++) begin
            m = (k < 5) ? specials[k] : $urandom;
            push32(m);
            op32(m, $urandom, "random32");
        end
    endtask

    task automatic test_back_to_back();
        int done_n = 0, load_n = 0;
        int done_at [3] = '{-1, -1, -1};
        logic [31:0] m = 32'h9E37_79B9;
        for (int k = 0; k < 3; k++) push32(m);
        if32.multiplier   = m;
        if32.multiplicand = 32'h0BAD_F00D;
        if32.start        = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (if32.load) load_n++;
            if (if32.done) begin
                if (done_n < 3) done_at[done_n] = c;
                done_n++;
            end
            if (c == 33) if32.start = 1'b0;
        end
        n_cmp++;
        if (done_n != 3 || load_n != 3 || done_at[0] != 10 || done_at[1] != 21 || done_at[2] != 32) begin
            n_bad++;
            $display("FAIL back_to_back got done=%0d load=%0d at=%0d,%0d,%0d exp done=3 load=3 at=10,21,32",
                     done_n, load_n, done_at[0], done_at[1], done_at[2]);
        end
        n_cmp++;
        if (q32.size() != 0) begin
            n_bad++;
            $display("FAIL back_to_back digits_left got=%0d exp=0", q32.size());
        end
    endtask

    task automatic test_abort();
        int   load_n = 0, done_n = 0, dv_n = 0;
        logic ready5 = 1'b0, dv5 = 1'b1, mc_ok = 1'b1;
        logic [31:0] m = $urandom;
        push32(m);
        if32.multiplier   = m;
        if32.multiplicand = 32'hDEAD_BEEF;
        if32.start        = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (if32.load) load_n++;
            if (if32.done) done_n++;
            if (if32.digit_valid) dv_n++;
            if (if32.mcand_q !== 32'hDEAD_BEEF) mc_ok = 1'b0;
            if (c == 5) begin
                ready5 = if32.ready;
                dv5    = if32.digit_valid;
                if32.abort = 1'b0;
            end
            if (c == 1) if32.start = 1'b0;
            if (c == 4) if32.abort = 1'b1;
        end
        n_cmp++;
        if (ready5 !== 1'b1 || dv5 !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle got ready=%b dv=%b exp ready=1 dv=0", ready5, dv5);
        end
        n_cmp++;
        if (done_n != 0 || load_n != 1 || dv_n != 3 || mc_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_effects got done=%0d load=%0d dv=%0d mc_ok=%b exp done=0 load=1 dv=3 mc_ok=1",
                     done_n, load_n, dv_n, mc_ok);
        end
        n_cmp++;
        if (q32.size() != 5) begin
            n_bad++;
            $display("FAIL abort_digits_left got=%0d exp=5", q32.size());
        end
        q32.delete();
    endtask

    task automatic test_reset_in_clear();
        logic [17:0] snap8;
        push8(8'h7F);
        if8.multiplier   = 8'h7F;
        if8.multiplicand = 8'h5C;
        if8.start        = 1'b1;
        @(negedge clk);
        if8.start = 1'b0;
        n_cmp++;
        if (if8.load !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_clear_pre got load=%b exp=1", if8.load);
        end
        rst_n = 1'b0;
        #1;
        snap8 = {if8.ready, if8.load, if8.done, if8.digit_valid, if8.digit_neg,
                 if8.digit_mag, if8.digit_last, if8.mcand_q};
        n_cmp++;
        if (snap8 !== {1'b1, 17'b0}) begin
            n_bad++;
            $display("FAIL reset_clear_async got=%b exp=%b", snap8, {1'b1, 17'b0});
        end
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push8(8'h7F);
        op8(8'h7F, 8'h05, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_start_abort_idle();
        test_start_in_run();
        test_random();
        test_back_to_back();
        test_abort();
        test_reset_in_clear();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
